// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: signed binary to sign+BCD (shift-add-3) with time-multiplexed digit scan.
// Build option: SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits at display load.
module seg_scan_ctrl #(
    parameter int WIDTH    = 6,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  bin,
    input  logic              load,
    output logic              busy,
    output logic              done,
    output logic [DIGITS:0]   digit_sel,
    output logic [3:0]        digit_val
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [3:0] MINUS = 4'b1010;
    localparam logic [3:0] BLANK = 4'b1111;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [WIDTH-1:0]     r_mag;
    logic [WIDTH-1:0]     w_neg;
    logic [4*DIGITS-1:0]  r_bcd;
    logic [4*DIGITS-1:0]  w_bcd_adj;
    logic [4*DIGITS-1:0]  w_disp_next;
    logic [4*DIGITS-1:0]  r_disp;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_sign;
    logic [3:0]           r_disp_sign;
    logic [DW-1:0]        r_div;
    logic [DIGITS:0]      r_sel;
    logic                 w_last;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic                 w_lead;
`endif

    assign w_neg  = ~bin + {{(WIDTH-1){1'b0}}, 1'b1};
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: if (load) w_next = CONV;
            CONV: begin
                busy = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Add-3 correction applied before the shift so each nibble stays a valid BCD digit.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        w_disp_next = r_bcd;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        // Walk down from the top digit; digit 0 is never blanked.
        w_lead = 1'b1;
        for (int unsigned k = 0; k < DIGITS - 1; k++) begin
            if (w_lead && (r_bcd[4*(DIGITS-1-k) +: 4] == 4'd0))
                w_disp_next[4*(DIGITS-1-k) +: 4] = BLANK;
            else
                w_lead = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag       <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_sign      <= BLANK;
            r_disp      <= '0;
            r_disp_sign <= BLANK;
        end else begin
            case (r_state)
                IDLE: if (load) begin
                    r_mag  <= bin[WIDTH-1] ? w_neg : bin;
                    r_sign <= bin[WIDTH-1] ? MINUS : BLANK;
                    r_bcd  <= '0;
                    r_cnt  <= '0;
                end
                CONV: begin
                    {r_bcd, r_mag} <= {w_bcd_adj, r_mag} << 1;
                    r_cnt          <= r_cnt + 1'b1;
                end
                DONE: begin
                    r_disp      <= w_disp_next;
                    r_disp_sign <= r_sign;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_sel <= (DIGITS+1)'(1);
        end else if (r_div == DW'(SCAN_DIV - 1)) begin
            r_div <= '0;
            r_sel <= {r_sel[DIGITS-1:0], r_sel[DIGITS]};
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign digit_sel = r_sel;

    always_comb begin
        digit_val = '0;
        if (r_sel[DIGITS]) digit_val = r_disp_sign;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_sel[i]) digit_val = r_disp[4*i +: 4];
        end
    end

endmodule
